pipe_mem_dbus: RTL and testbench
================================

Name: pipe_mem_dbus

Overview:
MEM pipeline stage. It is the downstream end of the EXE→MEM valid/allowin handshake: it consumes `exe_mem_validto` and drives `mem_allowin`. It issues load/store transactions on a split address/data request bus (`dreq`/`daddr_ok`/`ddata_ok`) to the data memory and holds the instruction until the response arrives. It forwards results to WB through the same valid/allowin protocol and exports bypass/hazard info to ID.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus word width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
exe_mem_validto  in  1  EXE has valid instr for MEM
mem_allowin  out  1  MEM can accept this cycle
wb_allowin  in  1  WB can accept
mem_wb_validto  out  1  MEM has valid, completed instr for WB
flush_mem_wb  in  1  exception/eret flush of MEM
pc_in  in  32  instr PC
alu_result_in  in  32  ALU result / memory address
rt_in  in  32  store data
rdc_in  in  5  destination register
dmem_we_in  in  1  store instr
rf_we_in  in  1  regfile write enable
lw_instr_in  in  1  load instr
ex_in  in  1  exception already raised upstream
ex_code_in  in  5  upstream exception code
dreq  out  1  bus request
dwr  out  1  1=write, 0=read
daddr  out  ADDR_W  word address (`alu_result`)
dwdata  out  DATA_W  write data (`rt`)
daddr_ok  in  1  request accepted this cycle
ddata_ok  in  1  response/write-ack this cycle
drdata  in  DATA_W  read data, valid with `ddata_ok`
pc  out  32  registered PC
rd_data  out  32  load data if load, else `alu_result`
rdc_mem  out  5  registered destination
rf_we  out  1  registered rf_we
ex  out  1  exception flag to WB
ex_code  out  5  exception code to WB
mem_rdc_valid  out  1  `rf_we` & `mem_valid`, for ID bypass
mem_load_pending  out  1  load in MEM whose data is not yet returned; ID must stall

Behaviour:
- Reset: `mem_valid`=0, state=IDLE, `dreq`=0, all registered outputs 0, `mem_allowin`=1.
- Handshake:
  - `mem_allowin` = !`mem_valid` || (`mem_ready_go` && `wb_allowin`) && state!=DRAIN.
  - On a clk edge with `mem_allowin`: `mem_valid` <= `exe_mem_validto`. Payload registers load only when `exe_mem_validto` & `mem_allowin`.
  - `mem_wb_validto` = `mem_valid` & `mem_ready_go` & !`flush_mem_wb`.
- `mem_access` = `mem_valid` & (`lw_instr` | `dmem_we`) & !`ex`. Instructions with `ex` set never touch the bus.
- `mem_ready_go` = !`mem_access` | state==DONE.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE→REQ on the edge that captures a memory-access instr.
  - REQ: `dreq`=1, with `dwr`/`daddr`/`dwdata` stable. On `daddr_ok`→WAIT.
  - WAIT: on `ddata_ok`, latch `drdata` into the read buffer →DONE.
  - DONE: hold until the stage advances. On advance, →REQ if the newly captured instr is a memory access, else →IDLE.
  - Bus rule: `ddata_ok` never arrives in the same cycle as its own `daddr_ok`. One outstanding request max.
- Flush:
  - `flush_mem_wb` clears `mem_valid` at the next edge.
  - REQ & flush & !`daddr_ok`: →IDLE, request withdrawn.
  - REQ & flush & `daddr_ok`: →DRAIN.
  - WAIT & flush: →DRAIN.
  - DRAIN: `dreq`=0, `mem_allowin`=0. On `ddata_ok`→IDLE, data discarded.
  - DONE & flush: →IDLE.
- `rd_data` = `lw_instr` ? read buffer : `alu_result`. Word accesses only.
- `mem_load_pending` = `mem_valid` & `lw_instr` & !`ex` & state!=DONE.
- `ex`/`ex_code` pass through registered.
- Reset mid-transaction: returns to IDLE immediately. A late `ddata_ok` while IDLE is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - `alu_result`[1:0]!=0 on a load sets `ex`=1, `ex_code`=5'h04 (AdEL).
  - On a store it sets `ex`=1, `ex_code`=5'h05 (AdES).
  - The access is suppressed (no `dreq`); `mem_ready_go`=1.
  - An upstream `ex_in` takes priority.
- Undefined: no alignment check; the low address bits are driven unchanged on `daddr`.

Test Plan:
- Non-memory instr, `rf_we`=1, `alu_result`=0x1234 → `mem_wb_validto` 1 cycle after capture, `rd_data`=0x1234, `dreq` never asserted.
- Load `addr`=0x100, `daddr_ok` after 2 cycles, `ddata_ok` 3 cycles later with 0xDEADBEEF → `dreq` high 3 cycles; `mem_allowin`=0 until DONE; `rd_data`=0xDEADBEEF; `mem_load_pending` drops in DONE.
- Store `addr`=0x200, `rt`=0xA5A5A5A5, immediate `daddr_ok` → `dwr`=1, `dwdata`=0xA5A5A5A5; completes on `ddata_ok`; `rf_we`=0 forwarded.
- Back-to-back loads with `wb_allowin`=1 → second request issued the cycle after first DONE advance (DONE→REQ); no bubble beyond bus latency.
- Flush in WAIT → DRAIN, `mem_allowin`=0 until `ddata_ok`; no `mem_wb_validto`; next instr accepted afterwards.
- MEM_ALIGN_CHK_EN defined, load `addr`=0x102 → no `dreq`, `ex`=1, `ex_code`=0x04, `mem_wb_validto` next cycle.

Source files
------------

// File: rtl/pipe_mem_dbus.sv
// MEM pipeline stage: valid/allowin handshake with EXE and WB, split address/data bus for loads and stores.
// Optional alignment check (AdEL/AdES) enabled by defining MEM_ALIGN_CHK_EN.
module pipe_mem_dbus #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exe_mem_validto,
    output logic              mem_allowin,
    input  logic              wb_allowin,
    output logic              mem_wb_validto,
    input  logic              flush_mem_wb,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       rt_in,
    input  logic [4:0]        rdc_in,
    input  logic              dmem_we_in,
    input  logic              rf_we_in,
    input  logic              lw_instr_in,
    input  logic              ex_in,
    input  logic [4:0]        ex_code_in,
    output logic              dreq,
    output logic              dwr,
    output logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] dwdata,
    input  logic              daddr_ok,
    input  logic              ddata_ok,
    input  logic [DATA_W-1:0] drdata,
    output logic [31:0]       pc,
    output logic [31:0]       rd_data,
    output logic [4:0]        rdc_mem,
    output logic              rf_we,
    output logic              ex,
    output logic [4:0]        ex_code,
    output logic              mem_rdc_valid,
    output logic              mem_load_pending
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic              mem_valid_q;
    logic [31:0]       pc_q, alu_q;
    logic [DATA_W-1:0] rt_q, rbuf_q;
    logic [4:0]        rdc_q, ex_code_q;
    logic              we_q, rf_we_q, lw_q, ex_q;

    logic              mem_access, mem_ready_go, capture, new_access, ex_new;
    logic [4:0]        ex_code_new;

`ifdef MEM_ALIGN_CHK_EN
    logic misalign;
    assign misalign    = (alu_result_in[1:0] != 2'b00) & (lw_instr_in | dmem_we_in);
    // Upstream exceptions win over the alignment fault.
    assign ex_new      = ex_in | misalign;
    assign ex_code_new = (!ex_in && misalign) ? (lw_instr_in ? 5'h04 : 5'h05) : ex_code_in;
`else
    assign ex_new      = ex_in;
    assign ex_code_new = ex_code_in;
`endif

    assign mem_access     = mem_valid_q & (lw_q | we_q) & ~ex_q;
    assign mem_ready_go   = ~mem_access | (state_q == S_DONE);
    assign mem_allowin    = (~mem_valid_q | (mem_ready_go & wb_allowin)) & (state_q != S_DRAIN);
    assign mem_wb_validto = mem_valid_q & mem_ready_go & ~flush_mem_wb;
    assign capture        = exe_mem_validto & mem_allowin & ~flush_mem_wb;
    assign new_access     = (lw_instr_in | dmem_we_in) & ~ex_new;

    assign dreq             = (state_q == S_REQ);
    assign dwr              = we_q;
    assign daddr            = alu_q[ADDR_W-1:0];
    assign dwdata           = rt_q;
    assign pc               = pc_q;
    assign rd_data          = lw_q ? 32'(rbuf_q) : alu_q;
    assign rdc_mem          = rdc_q;
    assign rf_we            = rf_we_q;
    assign ex               = ex_q;
    assign ex_code          = ex_code_q;
    assign mem_rdc_valid    = rf_we_q & mem_valid_q;
    assign mem_load_pending = mem_valid_q & lw_q & ~ex_q & (state_q != S_DONE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (capture && new_access) state_d = S_REQ;
            S_REQ: begin
                // A flushed request already accepted must still have its response drained.
                if (flush_mem_wb) state_d = daddr_ok ? S_DRAIN : S_IDLE;
                else if (daddr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush_mem_wb)  state_d = ddata_ok ? S_IDLE : S_DRAIN;
                else if (ddata_ok) state_d = S_DONE;
            end
            S_DONE: begin
                if (flush_mem_wb)     state_d = S_IDLE;
                else if (mem_allowin) state_d = (capture && new_access) ? S_REQ : S_IDLE;
            end
            S_DRAIN: if (ddata_ok) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q <= 1'b0;
            pc_q        <= '0;
            alu_q       <= '0;
            rt_q        <= '0;
            rdc_q       <= '0;
            we_q        <= 1'b0;
            rf_we_q     <= 1'b0;
            lw_q        <= 1'b0;
            ex_q        <= 1'b0;
            ex_code_q   <= '0;
            rbuf_q      <= '0;
        end else begin
            if (flush_mem_wb)     mem_valid_q <= 1'b0;
            else if (mem_allowin) mem_valid_q <= exe_mem_validto;
            if (capture) begin
                pc_q      <= pc_in;
                alu_q     <= alu_result_in;
                rt_q      <= DATA_W'(rt_in);
                rdc_q     <= rdc_in;
                we_q      <= dmem_we_in;
                rf_we_q   <= rf_we_in;
                lw_q      <= lw_instr_in;
                ex_q      <= ex_new;
                ex_code_q <= ex_code_new;
            end
            if (state_q == S_WAIT && ddata_ok) rbuf_q <= drdata;
        end
    end

endmodule

// File: tb/tb_pipe_mem_dbus.sv
// Scoreboard bench for pipe_mem_dbus: directed scenarios, then randomized traffic against a
// word-addressed memory model with a randomly timed bus responder and WB back-pressure.
module tb_pipe_mem_dbus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_mem_validto = 1'b0, mem_allowin, wb_allowin, mem_wb_validto;
    logic        flush_mem_wb = 1'b0;
    logic [31:0] pc_in = '0, alu_result_in = '0, rt_in = '0;
    logic [4:0]  rdc_in = '0, ex_code_in = '0;
    logic        dmem_we_in = 1'b0, rf_we_in = 1'b0, lw_instr_in = 1'b0, ex_in = 1'b0;
    logic        dreq, dwr, daddr_ok = 1'b0, ddata_ok = 1'b0;
    logic [31:0] daddr, dwdata, drdata = '0;
    logic [31:0] pc, rd_data;
    logic [4:0]  rdc_mem, ex_code;
    logic        rf_we, ex, mem_rdc_valid, mem_load_pending;

    pipe_mem_dbus #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .exe_mem_validto(exe_mem_validto), .mem_allowin(mem_allowin),
        .wb_allowin(wb_allowin), .mem_wb_validto(mem_wb_validto), .flush_mem_wb(flush_mem_wb),
        .pc_in(pc_in), .alu_result_in(alu_result_in), .rt_in(rt_in), .rdc_in(rdc_in),
        .dmem_we_in(dmem_we_in), .rf_we_in(rf_we_in), .lw_instr_in(lw_instr_in), .ex_in(ex_in),
        .ex_code_in(ex_code_in), .dreq(dreq), .dwr(dwr), .daddr(daddr), .dwdata(dwdata),
        .daddr_ok(daddr_ok), .ddata_ok(ddata_ok), .drdata(drdata), .pc(pc), .rd_data(rd_data),
        .rdc_mem(rdc_mem), .rf_we(rf_we), .ex(ex), .ex_code(ex_code),
        .mem_rdc_valid(mem_rdc_valid), .mem_load_pending(mem_load_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, alu, rt;
        logic [4:0]  rdc, code;
        logic        we, rfwe, lw, ex;
    } ins_t;
    typedef struct {
        logic [31:0] pc, rd;
        logic [4:0]  rdc, code;
        logic        rf_we, ex;
        bit          chk_rd;
    } exp_t;
    typedef struct {
        logic [31:0] addr, wdata;
        logic        wr;
    } bus_t;

    exp_t        exp_q[$];
    bus_t        bus_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] bus_mem [logic [31:0]];
    int          checks = 0;
    int          failures = 0;
    bit          wb_rand = 1'b0;
    bit          stop = 1'b0;
    bit          to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] rd_bus(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
    endfunction

    function automatic ins_t mk(input logic [31:0] p, input logic [31:0] a, input logic [31:0] r,
                                input logic [4:0] d, input logic w, input logic f,
                                input logic l, input logic e, input logic [4:0] c);
        ins_t i;
        i.pc = p; i.alu = a; i.rt = r; i.rdc = d; i.we = w; i.rfwe = f; i.lw = l; i.ex = e; i.code = c;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t  i;
        int    r = int'($urandom_range(0, 19));
        i.pc   = $urandom;
        i.rt   = $urandom;
        i.rdc  = 5'($urandom_range(0, 31));
        i.code = 5'($urandom_range(0, 31));
        i.lw   = (r < 8);
        i.we   = (r >= 8 && r < 13);
        i.ex   = (r >= 18);
        if (i.ex) begin
            i.lw = 1'($urandom_range(0, 1));
            i.we = 1'($urandom_range(0, 1));
        end
        i.alu  = (i.lw || i.we) ? 32'h100 + 32'($urandom_range(0, 15) * 4) : $urandom;
        i.rfwe = i.lw ? 1'b1 : (i.we ? 1'b0 : 1'($urandom_range(0, 1)));
        return i;
    endfunction

    // Presents one instruction to MEM, waits for acceptance, and records what it must produce.
    task automatic issue(input ins_t i, input bit track_out, input bit track_bus);
        int          n = 0;
        logic        exf;
        logic [4:0]  cd;
        exp_t        e;
        bus_t        b;
        @(negedge clk);
        pc_in = i.pc; alu_result_in = i.alu; rt_in = i.rt; rdc_in = i.rdc; dmem_we_in = i.we;
        rf_we_in = i.rfwe; lw_instr_in = i.lw; ex_in = i.ex; ex_code_in = i.code;
        exe_mem_validto = 1'b1;
        #1;
        while (!mem_allowin && n < 500) begin
            @(negedge clk); #1; n++;
        end
        if (!mem_allowin) begin
            checks++; failures++;
            $display("FAIL issue_timeout actual=stalled required=accepted pc=%h", i.pc);
            exe_mem_validto = 1'b0;
            return;
        end
        exf = i.ex; cd = i.code;
`ifdef MEM_ALIGN_CHK_EN
        if (!i.ex && (i.lw || i.we) && i.alu[1:0] != 2'b00) begin
            exf = 1'b1;
            cd  = i.lw ? 5'h04 : 5'h05;
        end
`endif
        if (track_out) begin
            e.pc = i.pc; e.rdc = i.rdc; e.rf_we = i.rfwe; e.ex = exf; e.code = cd;
            e.rd = i.lw ? rd_ref(i.alu) : i.alu;
            e.chk_rd = !(i.lw && exf);
            exp_q.push_back(e);
        end
        if ((i.lw || i.we) && !exf) begin
            if (track_bus) begin
                b.addr = i.alu; b.wr = i.we; b.wdata = i.rt;
                bus_q.push_back(b);
            end
            if (i.we && track_out) ref_mem[i.alu] = i.rt;
        end
        @(posedge clk); #1;
        exe_mem_validto = 1'b0;
    endtask

    // Serves one bus transaction: accept a_dly cycles after dreq, respond d_dly cycles later.
    task automatic serve_one(input int a_dly, input int d_dly, input int max_wait, output bit tmo);
        int          n = 0;
        logic        wr;
        logic [31:0] rdv;
        tmo = 1'b0;
        @(negedge clk);
        while (!dreq && n < max_wait) begin
            @(negedge clk); n++;
        end
        if (!dreq) begin
            tmo = 1'b1;
            return;
        end
        repeat (a_dly) @(negedge clk);
        if (!dreq) return;
        daddr_ok = 1'b1;
        wr = dwr;
        if (dwr) begin
            bus_mem[daddr] = dwdata;
            rdv = $urandom;
        end else begin
            rdv = rd_bus(daddr);
        end
        @(negedge clk);
        daddr_ok = 1'b0;
        repeat (d_dly - 1) @(negedge clk);
        ddata_ok = 1'b1;
        drdata = wr ? $urandom : rdv;
        @(negedge clk);
        ddata_ok = 1'b0;
        drdata = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        wb_allowin = 1'b1;
        forever begin
            @(negedge clk);
            wb_allowin = wb_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every WB transfer and every accepted bus request.
    initial begin
        exp_t e;
        bus_t b;
        forever begin
            @(negedge clk); #2;
            if (!rst && mem_wb_validto && wb_allowin) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wb_unexpected actual=pc %h required=no transfer", pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_pc", pc, e.pc);
                    chk("wb_rdc", 32'(rdc_mem), 32'(e.rdc));
                    chk("wb_rf_we", 32'(rf_we), 32'(e.rf_we));
                    chk("wb_rdc_valid", 32'(mem_rdc_valid), 32'(e.rf_we));
                    chk("wb_ex", 32'(ex), 32'(e.ex));
                    chk("wb_ex_code", 32'(ex_code), 32'(e.code));
                    if (e.chk_rd) chk("wb_rd_data", rd_data, e.rd);
                end
            end
            if (!rst && dreq && daddr_ok) begin
                if (bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected actual=addr %h required=no request", daddr);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", daddr, b.addr);
                    chk("bus_wr", 32'(dwr), 32'(b.wr));
                    if (b.wr) chk("bus_wdata", dwdata, b.wdata);
                end
            end
        end
    end

    initial begin
        int dcnt;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_allowin", 32'(mem_allowin), 32'd1);
        chk("rst_dreq", 32'(dreq), 32'd0);
        chk("rst_wb_valid", 32'(mem_wb_validto), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rdc_ex", {22'd0, rdc_mem, ex_code}, 32'd0);
        chk("rst_flags", {27'd0, rf_we, ex, mem_rdc_valid, mem_load_pending, dwr}, 32'd0);

        // Non-memory instruction
        issue(mk(32'h1000, 32'h1234, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 1, 1);
        @(negedge clk); #1;
        chk("alu_valid_next", 32'(mem_wb_validto), 32'd1);
        chk("alu_no_dreq", 32'(dreq), 32'd0);
        drain();

        // Load with slow address accept and slow data
        ref_mem[32'h100] = 32'hDEADBEEF;
        bus_mem[32'h100] = 32'hDEADBEEF;
        issue(mk(32'h1004, 32'h100, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 1, 1);
        fork
            begin
                serve_one(2, 3, 50, to);
                chk("ld_serve_timeout", 32'(to), 32'd0);
            end
            begin
                dcnt = 0; n = 0;
                @(negedge clk); #1;
                while (!mem_wb_validto && n < 40) begin
                    chk("ld_allowin_busy", 32'(mem_allowin), 32'd0);
                    chk("ld_pending_busy", 32'(mem_load_pending), 32'd1);
                    dcnt += int'(dreq);
                    n++;
                    @(negedge clk); #1;
                end
                chk("ld_dreq_cycles", 32'(dcnt), 32'd3);
                chk("ld_pending_done", 32'(mem_load_pending), 32'd0);
                chk("ld_allowin_done", 32'(mem_allowin), 32'd1);
            end
        join
        drain();

        // Store with immediate accept
        issue(mk(32'h1008, 32'h200, 32'hA5A5A5A5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0), 1, 1);
        fork
            begin
                serve_one(0, 2, 50, to);
                chk("st_serve_timeout", 32'(to), 32'd0);
            end
            begin
                @(negedge clk); #1;
                chk("st_dreq", 32'(dreq), 32'd1);
                chk("st_dwr", 32'(dwr), 32'd1);
                chk("st_dwdata", dwdata, 32'hA5A5A5A5);
                chk("st_rdc_valid", 32'(mem_rdc_valid), 32'd0);
            end
        join
        drain();

        // Back-to-back loads: second request right after the first leaves DONE
        fork
            begin
                issue(mk(32'h100C, 32'h104, 32'h0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 1, 1);
                issue(mk(32'h1010, 32'h108, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 1, 1);
            end
            begin
                serve_one(0, 1, 50, to);
                chk("b2b_serve1_timeout", 32'(to), 32'd0);
                #1;
                chk("b2b_first_valid", 32'(mem_wb_validto), 32'd1);
                chk("b2b_allowin", 32'(mem_allowin), 32'd1);
                @(negedge clk); #1;
                chk("b2b_second_dreq", 32'(dreq), 32'd1);
                chk("b2b_second_addr", daddr, 32'h108);
                serve_one(0, 1, 50, to);
                chk("b2b_serve2_timeout", 32'(to), 32'd0);
            end
        join
        drain();

        // Flush while waiting for data
        issue(mk(32'h1014, 32'h10C, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 0, 1);
        @(negedge clk);
        chk("fl_dreq", 32'(dreq), 32'd1);
        daddr_ok = 1'b1;
        @(negedge clk);
        daddr_ok = 1'b0;
        flush_mem_wb = 1'b1;
        #1;
        chk("fl_no_valid", 32'(mem_wb_validto), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            flush_mem_wb = 1'b0;
            #1;
            chk("drain_allowin", 32'(mem_allowin), 32'd0);
            chk("drain_dreq", 32'(dreq), 32'd0);
            chk("drain_no_valid", 32'(mem_wb_validto), 32'd0);
        end
        @(negedge clk);
        ddata_ok = 1'b1;
        drdata = $urandom;
        #1;
        chk("drain_allowin_ack", 32'(mem_allowin), 32'd0);
        @(negedge clk);
        ddata_ok = 1'b0;
        #1;
        chk("drain_exit_allowin", 32'(mem_allowin), 32'd1);
        chk("drain_exit_valid", 32'(mem_wb_validto), 32'd0);
        issue(mk(32'h1018, 32'h5555AAAA, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0), 1, 1);
        drain();

        // Flush in REQ before accept withdraws the request
        issue(mk(32'h101C, 32'h110, 32'h0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 0, 0);
        @(negedge clk);
        chk("wd_dreq", 32'(dreq), 32'd1);
        flush_mem_wb = 1'b1;
        @(negedge clk);
        flush_mem_wb = 1'b0;
        #1;
        chk("wd_dreq_gone", 32'(dreq), 32'd0);
        chk("wd_allowin", 32'(mem_allowin), 32'd1);

        // Reset during an outstanding request; a late response must be ignored
        issue(mk(32'h1020, 32'h114, 32'h0, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 0, 0);
        @(negedge clk);
        chk("rs_dreq", 32'(dreq), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        bus_q.delete();
        #1;
        chk("rs_dreq_clr", 32'(dreq), 32'd0);
        chk("rs_allowin", 32'(mem_allowin), 32'd1);
        chk("rs_pending", 32'(mem_load_pending), 32'd0);
        ddata_ok = 1'b1;
        drdata = 32'hBAD0BAD0;
        @(negedge clk);
        ddata_ok = 1'b0;
        #1;
        chk("late_ack_dreq", 32'(dreq), 32'd0);
        chk("late_ack_valid", 32'(mem_wb_validto), 32'd0);
        chk("late_ack_allowin", 32'(mem_allowin), 32'd1);
        fork
            issue(mk(32'h1024, 32'h118, 32'h0, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 1, 1);
            begin
                serve_one(1, 2, 50, to);
                chk("rs_serve_timeout", 32'(to), 32'd0);
            end
        join
        drain();

        // Misaligned load
`ifdef MEM_ALIGN_CHK_EN
        issue(mk(32'h1028, 32'h102, 32'h0, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 1, 1);
        @(negedge clk); #1;
        chk("mis_no_dreq", 32'(dreq), 32'd0);
        chk("mis_valid_next", 32'(mem_wb_validto), 32'd1);
        chk("mis_ex", 32'(ex), 32'd1);
        chk("mis_ex_code", 32'(ex_code), 32'h04);
        drain();
        issue(mk(32'h102C, 32'h201, 32'h77, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0), 1, 1);
        drain();
`else
        fork
            issue(mk(32'h1028, 32'h102, 32'h0, 5'd13, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0), 1, 1);
            begin
                serve_one(0, 1, 50, to);
                chk("mis_serve_timeout", 32'(to), 32'd0);
            end
            begin
                @(negedge clk); @(negedge clk); #1;
                chk("mis_daddr_raw", daddr, 32'h102);
            end
        join
        drain();
`endif

        // Randomized traffic with back-pressure and random bus latency
        wb_rand = 1'b1;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                    issue(rand_ins(), 1, 1);
                end
                drain();
                stop = 1'b1;
            end
            begin
                while (!stop) serve_one(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 20, to);
            end
        join
        wb_rand = 1'b0;
        chk("final_bus_queue", 32'(bus_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
